// File: rtl/scr1_dmem_dword_initiator.sv
// SCR1 dmem initiator: one 64-bit command becomes a sequence of 32-bit word
// transfers; reads are coherent (HI, LO, HI) with bounded retry on HI change.
package scr1_dmem_dword_pkg;
   localparam int SCR1_DMEM_AWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_dword_initiator
   import scr1_dmem_dword_pkg::*;
#(
   parameter int AWIDTH    = SCR1_DMEM_AWIDTH,
   parameter int RETRY_MAX = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [AWIDTH-1:0]    cmd_addr,
   input  logic [63:0]          cmd_wdata,
   output logic                 rsp_valid,
   output logic                 rsp_err,
   output logic [63:0]          rsp_rdata,
   output logic                 dmem_req,
   output type_scr1_mem_cmd_e   dmem_cmd,
   output type_scr1_mem_width_e dmem_width,
   output logic [AWIDTH-1:0]    dmem_addr,
   output logic [31:0]          dmem_wdata,
   input  logic                 dmem_req_ack,
   input  logic [31:0]          dmem_rdata,
   input  type_scr1_mem_resp_e  dmem_resp
);

   typedef enum logic [1:0] {
      ST_IDLE, ST_REQ, ST_RESP, ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      PH_WR_LO, PH_WR_HI, PH_RD_HI0, PH_RD_LO, PH_RD_HI1
   } phase_e;

   localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   localparam logic [RW-1:0]     RMAX  = RW'(RETRY_MAX);
   localparam logic [AWIDTH-1:0] WSTEP = AWIDTH'(4);

   state_e             state_q;
   phase_e             phase_q;
   logic [AWIDTH-1:0]  addr_q;
   logic [31:0]        whi_q;
   logic [31:0]        hi0_q;
   logic [31:0]        lo_q;
   logic [RW-1:0]      retry_q;

   logic               req_q;
   type_scr1_mem_cmd_e cmd_q;
   logic [AWIDTH-1:0]  daddr_q;
   logic [31:0]        dwdata_q;
   logic               rvalid_q;
   logic               rerr_q;
   logic [63:0]        rdata_q;

   logic [AWIDTH-1:0]  addr_hi_d;
   logic [AWIDTH-1:0]  cmd_hi_d;

   // HI word address wraps modulo 2^AWIDTH
   assign addr_hi_d = addr_q + WSTEP;
   assign cmd_hi_d  = cmd_addr + WSTEP;

   assign cmd_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = rvalid_q;
   assign rsp_err    = rerr_q;
   assign rsp_rdata  = rdata_q;
   assign dmem_req   = req_q;
   assign dmem_cmd   = cmd_q;
   assign dmem_width = SCR1_MEM_WIDTH_WORD;
   assign dmem_addr  = daddr_q;
   assign dmem_wdata = dwdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         phase_q  <= PH_WR_LO;
         addr_q   <= '0;
         whi_q    <= '0;
         hi0_q    <= '0;
         lo_q     <= '0;
         retry_q  <= '0;
         req_q    <= 1'b0;
         cmd_q    <= SCR1_MEM_CMD_RD;
         daddr_q  <= '0;
         dwdata_q <= '0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  whi_q   <= cmd_wdata[63:32];
                  retry_q <= '0;
                  if (cmd_addr[2:0] != 3'b000) begin
                     state_q  <= ST_DONE;
                     rvalid_q <= 1'b1;
                     rerr_q   <= 1'b1;
                     rdata_q  <= '0;
                  end else if (cmd_write) begin
                     state_q  <= ST_REQ;
                     phase_q  <= PH_WR_LO;
                     req_q    <= 1'b1;
                     cmd_q    <= SCR1_MEM_CMD_WR;
                     daddr_q  <= cmd_addr;
                     dwdata_q <= cmd_wdata[31:0];
                  end else begin
                     state_q  <= ST_REQ;
                     phase_q  <= PH_RD_HI0;
                     req_q    <= 1'b1;
                     cmd_q    <= SCR1_MEM_CMD_RD;
                     daddr_q  <= cmd_hi_d;
                     dwdata_q <= '0;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_req_ack) begin
                  req_q   <= 1'b0;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               case (dmem_resp)
                  SCR1_MEM_RESP_NOTRDY: ;
                  SCR1_MEM_RESP_RDY_OK: begin
                     unique case (phase_q)
                        PH_WR_LO: begin
                           phase_q  <= PH_WR_HI;
                           state_q  <= ST_REQ;
                           req_q    <= 1'b1;
                           daddr_q  <= addr_hi_d;
                           dwdata_q <= whi_q;
                        end
                        PH_WR_HI: begin
                           state_q  <= ST_DONE;
                           rvalid_q <= 1'b1;
                           rerr_q   <= 1'b0;
                           rdata_q  <= '0;
                        end
                        PH_RD_HI0: begin
                           hi0_q   <= dmem_rdata;
                           phase_q <= PH_RD_LO;
                           state_q <= ST_REQ;
                           req_q   <= 1'b1;
                           daddr_q <= addr_q;
                        end
                        PH_RD_LO: begin
                           lo_q    <= dmem_rdata;
                           phase_q <= PH_RD_HI1;
                           state_q <= ST_REQ;
                           req_q   <= 1'b1;
                           daddr_q <= addr_hi_d;
                        end
                        PH_RD_HI1: begin
                           if (dmem_rdata == hi0_q) begin
                              state_q  <= ST_DONE;
                              rvalid_q <= 1'b1;
                              rerr_q   <= 1'b0;
                              rdata_q  <= {dmem_rdata, lo_q};
                           end else if (retry_q != RMAX) begin
                              // carry crossed LO: re-read LO against the new HI
                              hi0_q   <= dmem_rdata;
                              retry_q <= retry_q + 1'b1;
                              phase_q <= PH_RD_LO;
                              state_q <= ST_REQ;
                              req_q   <= 1'b1;
                              daddr_q <= addr_q;
                           end else begin
                              state_q  <= ST_DONE;
                              rvalid_q <= 1'b1;
                              rerr_q   <= 1'b1;
                              rdata_q  <= {dmem_rdata, lo_q};
                           end
                        end
                        default: begin
                           state_q  <= ST_DONE;
                           rvalid_q <= 1'b1;
                           rerr_q   <= 1'b1;
                           rdata_q  <= '0;
                        end
                     endcase
                  end
                  default: begin
                     state_q  <= ST_DONE;
                     rvalid_q <= 1'b1;
                     rerr_q   <= 1'b1;
                     rdata_q  <= '0;
                  end
               endcase
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scr1_dmem_dword_initiator.sv
// Bench for scr1_dmem_dword_initiator: scripted/timer/memory responder and
// a reference model of the coherent 64-bit read sequence.
module tb_scr1_dmem_dword_initiator;
   import scr1_dmem_dword_pkg::*;

   localparam int RMAX = 2;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   logic                 clk;
   logic                 rst_n;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [31:0]          cmd_addr;
   logic [63:0]          cmd_wdata;
   logic                 rsp_valid;
   logic                 rsp_err;
   logic [63:0]          rsp_rdata;
   logic                 dmem_req;
   type_scr1_mem_cmd_e   dmem_cmd;
   type_scr1_mem_width_e dmem_width;
   logic [31:0]          dmem_addr;
   logic [31:0]          dmem_wdata;
   logic                 dmem_req_ack;
   logic [31:0]          dmem_rdata;
   type_scr1_mem_resp_e  dmem_resp;

   int n_cmp = 0;
   int n_bad = 0;

   xfer_t       tlog[$];
   logic [31:0] script[$];
   logic [31:0] mem [logic [31:0]];
   bit          timer_on = 0;
   logic [63:0] tmr;
   logic [63:0] tstep;
   int          ack_hold = 0;
   int          err_at = -1;
   int          stab_bad = 0;

   scr1_dmem_dword_initiator #(
      .AWIDTH(32),
      .RETRY_MAX(RMAX)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_err(rsp_err),
      .rsp_rdata(rsp_rdata),
      .dmem_req(dmem_req),
      .dmem_cmd(dmem_cmd),
      .dmem_width(dmem_width),
      .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata),
      .dmem_req_ack(dmem_req_ack),
      .dmem_rdata(dmem_rdata),
      .dmem_resp(dmem_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic xfer_t X(input logic wr, input logic [31:0] a,
                               input logic [31:0] d);
      xfer_t x;
      x.wr = wr;
      x.addr = a;
      x.wdata = d;
      return x;
   endfunction

   task automatic chk_xfers(input string tag, input xfer_t exp[$]);
      chk({tag, ".n"}, 64'(tlog.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < tlog.size(); i++) begin
         chk($sformatf("%s.wr%0d", tag, i), 64'(tlog[i].wr), 64'(exp[i].wr));
         chk($sformatf("%s.a%0d", tag, i), 64'(tlog[i].addr),
             64'(exp[i].addr));
         if (exp[i].wr)
            chk($sformatf("%s.d%0d", tag, i), 64'(tlog[i].wdata),
                64'(exp[i].wdata));
      end
   endtask

   // Reference for a read from a free-running 64-bit counter that advances
   // by step after every word access.
   function automatic void timer_model(input logic [63:0] t0,
                                       input logic [63:0] step,
                                       output logic [63:0] res,
                                       output bit err, output int n);
      logic [63:0] t;
      logic [31:0] hi0, lo, hi1;
      t = t0;
      hi0 = t[63:32];
      t += step;
      n = 1;
      res = '0;
      err = 1'b1;
      for (int r = 0; r <= RMAX; r++) begin
         lo = t[31:0];
         t += step;
         hi1 = t[63:32];
         t += step;
         n += 2;
         res = {hi1, lo};
         if (hi1 == hi0) begin
            err = 1'b0;
            break;
         end
         hi0 = hi1;
      end
   endfunction

   // Responder: ack (optionally held off), answer on the following cycle.
   initial begin
      bit          pend;
      bit          hseen;
      xfer_t       px;
      logic [31:0] h_addr, h_wd, w;
      logic        h_cmd;
      pend = 0;
      hseen = 0;
      dmem_req_ack = 1'b0;
      dmem_resp = SCR1_MEM_RESP_NOTRDY;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         dmem_req_ack = 1'b0;
         dmem_resp = SCR1_MEM_RESP_NOTRDY;
         dmem_rdata = '0;
         if (!rst_n) begin
            pend = 0;
            hseen = 0;
         end else if (pend) begin
            pend = 0;
            if (int'(tlog.size()) - 1 == err_at) begin
               dmem_resp = SCR1_MEM_RESP_RDY_ER;
            end else begin
               dmem_resp = SCR1_MEM_RESP_RDY_OK;
               if (px.wr) begin
                  mem[px.addr] = px.wdata;
               end else begin
                  if (script.size() > 0) w = script.pop_front();
                  else if (timer_on) begin
                     w = px.addr[2] ? tmr[63:32] : tmr[31:0];
                     tmr += tstep;
                  end else if (mem.exists(px.addr)) w = mem[px.addr];
                  else w = '0;
                  dmem_rdata = w;
               end
            end
         end else if (dmem_req) begin
            if (ack_hold > 0) begin
               if (!hseen) begin
                  hseen = 1;
                  h_addr = dmem_addr;
                  h_wd = dmem_wdata;
                  h_cmd = dmem_cmd;
               end else if (h_addr !== dmem_addr || h_wd !== dmem_wdata ||
                            h_cmd !== dmem_cmd)
                  stab_bad++;
               ack_hold--;
               // garbage response while request is pending must be ignored
               dmem_resp = SCR1_MEM_RESP_RDY_ER;
            end else begin
               if (hseen && (h_addr !== dmem_addr || h_wd !== dmem_wdata ||
                             h_cmd !== dmem_cmd))
                  stab_bad++;
               hseen = 0;
               dmem_req_ack = 1'b1;
               pend = 1;
               px = X(dmem_cmd == SCR1_MEM_CMD_WR, dmem_addr, dmem_wdata);
               tlog.push_back(px);
            end
         end
      end
   end

   task automatic do_cmd(input logic w, input logic [31:0] a,
                         input logic [63:0] wd, output int cyc,
                         output logic e, output logic [63:0] rd);
      tlog.delete();
      @(negedge clk);
      chk("cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr = a;
      cmd_wdata = wd;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      cyc = 0;
      e = 1'bx;
      rd = 'x;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            cyc = i;
            e = rsp_err;
            rd = rsp_rdata;
            break;
         end
      end
      @(negedge clk);
      chk("rsp_pulse", 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      int          cyc, n, h, cnt;
      logic        e, me;
      logic [63:0] rd, wd, mres, t0;
      logic [31:0] a;
      bit          berr;
      xfer_t       ex[$];

      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst.req", 64'(dmem_req), 64'd0);
      chk("rst.cmd", 64'(dmem_cmd), 64'(SCR1_MEM_CMD_RD));
      chk("rst.width", 64'(dmem_width), 64'(SCR1_MEM_WIDTH_WORD));
      chk("rst.addr", 64'(dmem_addr), 64'd0);
      chk("rst.wdata", 64'(dmem_wdata), 64'd0);
      chk("rst.valid", 64'(rsp_valid), 64'd0);
      chk("rst.err", 64'(rsp_err), 64'd0);
      chk("rst.rdata", rsp_rdata, 64'd0);
      chk("rst.ready", 64'(cmd_ready), 64'd1);
      rst_n = 1'b1;

      // 64-bit write, LO then HI
      do_cmd(1'b1, 32'h10, 64'h0000_0001_FFFF_FFF0, cyc, e, rd);
      chk("wr.cyc", 64'(cyc), 64'd5);
      chk("wr.err", 64'(e), 64'd0);
      ex = {X(1, 32'h10, 32'hFFFF_FFF0), X(1, 32'h14, 32'h1)};
      chk_xfers("wr", ex);

      // clean read
      script = {32'h5, 32'h1234, 32'h5};
      do_cmd(1'b0, 32'h08, '0, cyc, e, rd);
      chk("rd.cyc", 64'(cyc), 64'd7);
      chk("rd.err", 64'(e), 64'd0);
      chk("rd.data", rd, 64'h5_0000_1234);
      ex = {X(0, 32'h0C, 0), X(0, 32'h08, 0), X(0, 32'h0C, 0)};
      chk_xfers("rd", ex);

      // carry across LO during read
      script = {32'h4, 32'h2, 32'h5, 32'h3, 32'h5};
      do_cmd(1'b0, 32'h40, '0, cyc, e, rd);
      chk("roll.err", 64'(e), 64'd0);
      chk("roll.data", rd, 64'h5_0000_0003);
      chk("roll.n", 64'(tlog.size()), 64'd5);
      chk("roll.cyc", 64'(cyc), 64'd11);

      // HI never settles: retries exhausted
      script = {32'h1, 32'h0, 32'h2, 32'h0, 32'h3, 32'h0, 32'h4};
      do_cmd(1'b0, 32'h48, '0, cyc, e, rd);
      chk("pers.err", 64'(e), 64'd1);
      chk("pers.n", 64'(tlog.size()), 64'd7);
      chk("pers.data", rd, 64'h4_0000_0000);
      script.delete();

      // ack held off three cycles on the first word
      ack_hold = 3;
      stab_bad = 0;
      do_cmd(1'b1, 32'h50, 64'hA5A5_0000_1234_5678, cyc, e, rd);
      chk("hold.cyc", 64'(cyc), 64'd8);
      chk("hold.err", 64'(e), 64'd0);
      chk("hold.stable", 64'(stab_bad), 64'd0);
      ex = {X(1, 32'h50, 32'h1234_5678), X(1, 32'h54, 32'hA5A5_0000)};
      chk_xfers("hold", ex);

      // bus error on the LO write
      err_at = 0;
      do_cmd(1'b1, 32'h30, 64'h1111_2222_3333_4444, cyc, e, rd);
      err_at = -1;
      chk("ber.err", 64'(e), 64'd1);
      chk("ber.data", rd, 64'd0);
      chk("ber.cyc", 64'(cyc), 64'd3);
      chk("ber.n", 64'(tlog.size()), 64'd1);

      // misaligned command
      do_cmd(1'b0, 32'h4, '0, cyc, e, rd);
      chk("mis.cyc", 64'(cyc), 64'd1);
      chk("mis.err", 64'(e), 64'd1);
      chk("mis.n", 64'(tlog.size()), 64'd0);

      // top-of-space read
      script = {32'h9, 32'h8, 32'h9};
      do_cmd(1'b0, 32'hFFFF_FFF8, '0, cyc, e, rd);
      chk("top.data", rd, 64'h9_0000_0008);
      ex = {X(0, 32'hFFFF_FFFC, 0), X(0, 32'hFFFF_FFF8, 0),
            X(0, 32'hFFFF_FFFC, 0)};
      chk_xfers("top", ex);

      // random write then read-back through the memory responder
      for (int k = 0; k < 8; k++) begin
         a = 32'($urandom_range(0, 511)) << 3;
         wd = {$urandom, $urandom};
         h = $urandom_range(0, 2);
         ack_hold = h;
         do_cmd(1'b1, a, wd, cyc, e, rd);
         chk("rw.wcyc", 64'(cyc), 64'(5 + h));
         ex = {X(1, a, wd[31:0]), X(1, a + 32'd4, wd[63:32])};
         chk_xfers("rw.w", ex);
         do_cmd(1'b0, a, '0, cyc, e, rd);
         chk("rw.rcyc", 64'(cyc), 64'd7);
         chk("rw.rerr", 64'(e), 64'd0);
         chk("rw.rdata", rd, wd);
      end

      // random reads of a running counter near a LO rollover
      timer_on = 1;
      for (int k = 0; k < 10; k++) begin
         t0 = {32'($urandom_range(0, 15)),
               32'hFFFF_FFFF - 32'($urandom_range(0, 40))};
         tstep = 64'($urandom_range(1, 30));
         tmr = t0;
         timer_model(t0, tstep, mres, berr, n);
         do_cmd(1'b0, 32'h200, '0, cyc, e, rd);
         chk("tmr.data", rd, mres);
         chk("tmr.err", 64'(e), 64'(berr));
         chk("tmr.n", 64'(tlog.size()), 64'(n));
         chk("tmr.cyc", 64'(cyc), 64'(2 * n + 1));
      end
      timer_on = 0;

      // reset while a request is held
      tlog.delete();
      ack_hold = 5;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr = 32'h20;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rq.pre", 64'(dmem_req), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rq.req", 64'(dmem_req), 64'd0);
      chk("rq.ready", 64'(cmd_ready), 64'd1);
      chk("rq.addr", 64'(dmem_addr), 64'd0);
      ack_hold = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid || dmem_req) cnt++;
      end
      chk("rq.quiet", 64'(cnt), 64'd0);
      chk("rq.n", 64'(tlog.size()), 64'd0);

      // reset while waiting for a response
      tlog.delete();
      script = {32'h7, 32'h1, 32'h7};
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr = 32'h28;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rs.req", 64'(dmem_req), 64'd0);
      chk("rs.ready", 64'(cmd_ready), 64'd1);
      chk("rs.valid", 64'(rsp_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid || dmem_req) cnt++;
      end
      chk("rs.quiet", 64'(cnt), 64'd0);
      chk("rs.n", 64'(tlog.size()), 64'd1);
      script.delete();

      // recovery after reset
      do_cmd(1'b1, 32'h60, 64'hDEAD_BEEF_0BAD_F00D, cyc, e, rd);
      chk("rec.cyc", 64'(cyc), 64'd5);
      ex = {X(1, 32'h60, 32'h0BAD_F00D), X(1, 32'h64, 32'hDEAD_BEEF)};
      chk_xfers("rec", ex);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
